// File: rtl/regfile_pc_ras.sv
// Register file with program-counter unit and circular return-address stack.
module regfile_pc_ras #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PC_W       = 10,
    parameter int unsigned NREG       = 16,
    parameter int unsigned RAS_DEPTH  = 4,
    parameter int unsigned START_ADDR = 0
) (
    input  logic                      clk,
    input  logic                      start_n,
    input  logic                      hold,
    input  logic [3:0]                op,
    input  logic [$clog2(NREG)-1:0]   src,
    input  logic [$clog2(NREG)-1:0]   dst,
    input  logic [3:0]                imm,
    input  logic                      load_en,
    input  logic [DATA_W-1:0]         load_data,
    input  logic                      stor_en,
    output logic [DATA_W-1:0]         stor_data,
    output logic [PC_W-1:0]           pc,
    output logic                      branch_taken,
    output logic                      ras_overflow,
    output logic                      ras_underflow
);

    localparam int unsigned IDX_W  = $clog2(NREG);
    localparam int unsigned PAGE_W = PC_W - DATA_W;
    localparam int unsigned PTR_W  = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned Z_IDX  = NREG - 1;
    localparam int unsigned L_IDX  = NREG - 2;
    localparam logic [PC_W-1:0] LOW_MASK = {PC_W{1'b1}} >> PAGE_W;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MOV   = 4'd1,
        OP_INCR  = 4'd2,
        OP_DECR  = 4'd3,
        OP_BIZR  = 4'd4,
        OP_BNZR  = 4'd5,
        OP_LITLO = 4'd6,
        OP_LITHI = 4'd7,
        OP_LJMP  = 4'd8,
        OP_CALL  = 4'd9,
        OP_RET   = 4'd10,
        OP_MOVP  = 4'd11
    } op_e;

    logic [DATA_W-1:0] regs [NREG];
    logic [PC_W-1:0]   ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr;
    logic [CNT_W-1:0]  ras_cnt;

    logic [DATA_W-1:0] src_val;
    logic [DATA_W-1:0] z_val;
    logic [DATA_W-1:0] l_val;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   near_target;
    logic [PC_W-1:0]   far_target;

    logic              rf_we;
    logic [IDX_W-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [PC_W-1:0]   pc_next;
    logic              push;
    logic              pop;
    logic              taken;

    assign src_val   = regs[src];
    assign z_val     = regs[Z_IDX];
    assign l_val     = regs[L_IDX];
    assign pc_inc    = pc + PC_W'(1);
    assign stor_data = stor_en ? src_val : '0;

    // Decode op into one register write, next PC and RAS push/pop.
    always_comb begin
        rf_we       = 1'b0;
        rf_waddr    = dst;
        rf_wdata    = '0;
        pc_next     = pc_inc;
        push        = 1'b0;
        pop         = 1'b0;
        taken       = 1'b0;
        near_target = (pc & ~LOW_MASK) | PC_W'(z_val);
        far_target  = ((PC_W'(imm) << DATA_W) & ~LOW_MASK) | PC_W'(z_val);

        case (op_e'(op))
            OP_MOV: begin
                rf_we    = 1'b1;
                rf_wdata = (src == dst) ? '0 : src_val;
            end
            OP_INCR: begin
                rf_we    = 1'b1;
                rf_wdata = src_val + DATA_W'(imm[2:0]) + DATA_W'(1);
            end
            OP_DECR: begin
                rf_we    = 1'b1;
                rf_wdata = src_val - (DATA_W'(imm[2:0]) + DATA_W'(1));
            end
            OP_BIZR: begin
                if (src_val == '0) begin
                    pc_next = near_target;
                    taken   = 1'b1;
                end
            end
            OP_BNZR: begin
                if (src_val != '0) begin
                    pc_next = near_target;
                    taken   = 1'b1;
                end
            end
            OP_LITLO: begin
                rf_we    = 1'b1;
                rf_waddr = IDX_W'(L_IDX);
                rf_wdata = (l_val & ~DATA_W'(4'hF)) | DATA_W'(imm);
            end
            OP_LITHI: begin
                rf_we    = 1'b1;
                rf_waddr = IDX_W'(L_IDX);
                rf_wdata = (l_val & ~(DATA_W'(4'hF) << 4)) | (DATA_W'(imm) << 4);
            end
            OP_LJMP: begin
                pc_next = far_target;
                taken   = 1'b1;
            end
            OP_CALL: begin
                push    = 1'b1;
                pc_next = far_target;
                taken   = 1'b1;
            end
            OP_RET: begin
                pop   = 1'b1;
                taken = 1'b1;
                if (ras_cnt != '0) begin
                    pc_next = ras_mem[ras_ptr - PTR_W'(1)];
                end else begin
                    pc_next = PC_W'(START_ADDR);
                end
            end
            OP_MOVP: begin
                pc_next = (pc & ~LOW_MASK) | PC_W'(src_val);
            end
            default: ;
        endcase

        // Memory load wins the register write port; PC/RAS effects remain.
        if (load_en) begin
            rf_we    = 1'b1;
            rf_waddr = dst;
            rf_wdata = load_data;
        end
    end

    // State update: registers, PC, RAS and flags, frozen while hold is high.
    always_ff @(posedge clk or negedge start_n) begin
        if (!start_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            for (int j = 0; j < RAS_DEPTH; j++) begin
                ras_mem[j] <= '0;
            end
            ras_ptr       <= '0;
            ras_cnt       <= '0;
            pc            <= PC_W'(START_ADDR);
            branch_taken  <= 1'b0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (hold) begin
            branch_taken <= 1'b0;
        end else begin
            if (rf_we) begin
                regs[rf_waddr] <= rf_wdata;
            end
            pc           <= pc_next;
            branch_taken <= taken;
            if (push) begin
                ras_mem[ras_ptr] <= pc_inc;
                ras_ptr          <= ras_ptr + PTR_W'(1);
                if (ras_cnt == CNT_W'(RAS_DEPTH)) begin
                    ras_overflow <= 1'b1;
                end else begin
                    ras_cnt <= ras_cnt + CNT_W'(1);
                end
            end
            if (pop) begin
                if (ras_cnt != '0) begin
                    ras_ptr <= ras_ptr - PTR_W'(1);
                    ras_cnt <= ras_cnt - CNT_W'(1);
                end else begin
                    ras_underflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_pc_ras.sv
// Directed plus randomized bench against a queue-based reference model.
module tb_regfile_pc_ras;

    localparam int DATA_W = 8;
    localparam int PC_W   = 10;
    localparam int NREG   = 16;
    localparam int DEPTH  = 4;
    localparam int START  = 0;

    logic             clk;
    logic             start_n;
    logic             hold;
    logic [3:0]       op;
    logic [3:0]       src;
    logic [3:0]       dst;
    logic [3:0]       imm;
    logic             load_en;
    logic [7:0]       load_data;
    logic             stor_en;
    logic [7:0]       stor_data;
    logic [9:0]       pc;
    logic             branch_taken;
    logic             ras_overflow;
    logic             ras_underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_regs [NREG];
    int m_pc;
    int m_ras[$];
    int m_bt;
    int m_ovf;
    int m_unf;

    regfile_pc_ras #(
        .DATA_W(DATA_W), .PC_W(PC_W), .NREG(NREG),
        .RAS_DEPTH(DEPTH), .START_ADDR(START)
    ) dut (
        .clk(clk), .start_n(start_n), .hold(hold), .op(op), .src(src),
        .dst(dst), .imm(imm), .load_en(load_en), .load_data(load_data),
        .stor_en(stor_en), .stor_data(stor_data), .pc(pc),
        .branch_taken(branch_taken), .ras_overflow(ras_overflow),
        .ras_underflow(ras_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = 0;
        m_pc = START;
        m_ras.delete();
        m_bt = 0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    // One instruction's effect, computed from pre-edge state.
    task automatic model_step(input int o, input int s_i, input int d_i, input int im,
                              input int le, input int ld, input int hd);
        int s, z, l, page, npc, wa, wv;
        bit we;
        if (hd != 0) begin
            m_bt = 0;
            return;
        end
        s = m_regs[s_i];
        z = m_regs[NREG-1];
        l = m_regs[NREG-2];
        page = m_pc / 256;
        npc = (m_pc + 1) % 1024;
        we = 0; wa = d_i; wv = 0; m_bt = 0;
        case (o)
            1: begin we = 1; wv = (s_i == d_i) ? 0 : s; end
            2: begin we = 1; wv = (s + (im % 8) + 1) % 256; end
            3: begin we = 1; wv = (s - ((im % 8) + 1) + 256) % 256; end
            4: if (s == 0) begin npc = page * 256 + z; m_bt = 1; end
            5: if (s != 0) begin npc = page * 256 + z; m_bt = 1; end
            6: begin we = 1; wa = NREG - 2; wv = (l & 'hF0) | im; end
            7: begin we = 1; wa = NREG - 2; wv = (l & 'h0F) | (im * 16); end
            8: begin npc = (im % 4) * 256 + z; m_bt = 1; end
            9: begin
                m_ras.push_back((m_pc + 1) % 1024);
                if (m_ras.size() > DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1;
                end
                npc = (im % 4) * 256 + z;
                m_bt = 1;
            end
            10: begin
                if (m_ras.size() > 0) npc = m_ras.pop_back();
                else begin npc = START; m_unf = 1; end
                m_bt = 1;
            end
            11: npc = page * 256 + s;
            default: ;
        endcase
        if (le != 0) begin we = 1; wa = d_i; wv = ld; end
        if (we) m_regs[wa] = wv;
        m_pc = npc;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".pc"}, 32'(pc), 32'(m_pc));
        check({tag, ".bt"}, 32'(branch_taken), 32'(m_bt));
        check({tag, ".ovf"}, 32'(ras_overflow), 32'(m_ovf));
        check({tag, ".unf"}, 32'(ras_underflow), 32'(m_unf));
    endtask

    // Apply one instruction across a rising edge and compare afterwards.
    task automatic step(input string tag, input int o, input int s_i, input int d_i,
                        input int im, input int le = 0, input int ld = 0, input int hd = 0);
        op = 4'(o); src = 4'(s_i); dst = 4'(d_i); imm = 4'(im);
        load_en = 1'(le); load_data = 8'(ld); hold = 1'(hd); stor_en = 1'b0;
        @(posedge clk);
        model_step(o, s_i, d_i, im, le, ld, hd);
        #1;
        check_state(tag);
    endtask

    task automatic peek(input string tag, input int r, input int exp);
        src = 4'(r); stor_en = 1'b1;
        #1;
        check(tag, 32'(stor_data), 32'(exp));
        stor_en = 1'b0;
    endtask

    // Read every register through the store port within one cycle.
    task automatic check_regs(input string tag);
        for (int r = 0; r < NREG; r++) begin
            src = 4'(r); stor_en = 1'b1;
            #2;
            check($sformatf("%s.r%0d", tag, r), 32'(stor_data), 32'(m_regs[r]));
        end
        stor_en = 1'b0;
        #1;
        check({tag, ".stor_off"}, 32'(stor_data), 32'(0));
    endtask

    initial begin
        int ret_exp [4];
        start_n = 1'b0; hold = 1'b0; op = '0; src = '0; dst = '0; imm = '0;
        load_en = 1'b0; load_data = '0; stor_en = 1'b0;
        model_reset();
        #20;
        check_state("reset");
        check("reset.stor", 32'(stor_data), 32'(0));
        #100;
        start_n = 1'b1;

        step("nop1", 0, 0, 0, 0);
        check("nop1.pc_const", 32'(pc), 32'h1);
        step("nop2", 0, 0, 0, 0);
        step("nop3", 0, 0, 0, 0);
        check("nop3.pc_const", 32'(pc), 32'h3);

        step("litlo", 6, 0, 0, 4);
        step("lithi", 7, 0, 0, 2);
        peek("lit.L", 14, 'h24);
        step("movz", 1, 14, 15, 0);
        step("bizr", 4, 2, 0, 0);
        check("bizr.pc_const", 32'(pc), 32'h024);
        step("bnzr", 5, 2, 0, 0);
        check("bnzr.pc_const", 32'(pc), 32'h025);
        check("bnzr.bt_const", 32'(branch_taken), 32'(0));

        step("z10lo", 6, 0, 0, 0);
        step("z10hi", 7, 0, 0, 1);
        step("z10mv", 1, 14, 15, 0);
        step("call", 9, 0, 0, 2);
        check("call.pc_const", 32'(pc), 32'h210);
        step("ret", 10, 0, 0, 0);
        check("ret.pc_const", 32'(pc), 32'h029);
        check("ret.bt_const", 32'(branch_taken), 32'(1));

        for (int k = 0; k < 5; k++) step($sformatf("call%0d", k), 9, 0, 0, k % 4);
        check("ovf5.const", 32'(ras_overflow), 32'(1));
        ret_exp = '{'h311, 'h211, 'h111, 'h011};
        for (int k = 0; k < 4; k++) begin
            step($sformatf("lifo%0d", k), 10, 0, 0, 0);
            check($sformatf("lifo%0d.const", k), 32'(pc), 32'(ret_exp[k]));
        end
        step("ret_empty", 10, 0, 0, 0);
        check("unf.pc_const", 32'(pc), 32'(START));
        check("unf.const", 32'(ras_underflow), 32'(1));

        step("ld3", 0, 0, 3, 0, 1, 'hFE);
        step("incr", 2, 3, 4, 2);
        peek("incr.wrap", 4, 'h01);
        step("decr", 3, 0, 6, 0);
        peek("decr.wrap", 6, 'hFF);
        step("ld5", 0, 0, 5, 0, 1, 'h5A);
        step("mov_self", 1, 5, 5, 0);
        peek("mov_self.zero", 5, 0);
        step("ld_vs_incr", 2, 3, 7, 1, 1, 'hAB);
        peek("ld_vs_incr.val", 7, 'hAB);
        step("movp", 11, 7, 0, 0);
        check_regs("regs_a");

        step("ljmp", 8, 0, 0, 3);
        step("hold1", 2, 3, 3, 5, 1, 'h11, 1);
        step("hold2", 9, 0, 0, 1, 0, 0, 1);
        check_regs("regs_hold");

        // Asynchronous reset in the middle of a CALL cycle.
        op = 4'd9; imm = 4'd1; hold = 1'b0; load_en = 1'b0;
        #10;
        start_n = 1'b0;
        #1;
        model_reset();
        check_state("async_rst");
        #5;
        start_n = 1'b1;
        step("post_rst_ret", 10, 0, 0, 0);
        check_regs("regs_rst");

        for (int n = 0; n < 400; n++) begin
            int o, le, hd;
            o  = int'($urandom_range(0, 15));
            le = ($urandom_range(0, 7) == 0) ? 1 : 0;
            hd = ($urandom_range(0, 9) == 0) ? 1 : 0;
            step($sformatf("rnd%0d", n), o, int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 le, int'($urandom_range(0, 255)), hd);
            if (n % 16 == 15) check_regs($sformatf("rnd_regs%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
